// File: rtl/dense_streamer.sv
// dense_streamer: transmit-side sequencer for the dense-layer accelerator.
// For each output neuron it clears the accelerator and streams a header
// word, then (activation, weight) pairs, then the bias. After the stream
// drains, it writes the accelerator's Q8.24 result to the result memory.
// Every output is a flop. Control outputs are loaded from the next-state
// value, so each one lines up with the state that owns it.
module dense_streamer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       length,
  input  logic [15:0]       num_out,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] r_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] res_addr,
  output logic [31:0]       res_wdata,
  output logic              res_write,
  output logic              acc_reset_n,
  output logic [31:0]       acc_data,
  output logic              acc_valid,
  output logic [31:0]       acc_length,
  input  logic [31:0]       acc_result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]        state;
  logic [2:0]        next_state;

  // Command registers, captured when a start is accepted in IDLE.
  logic [15:0]       num_r;
  logic [ADDR_W-1:0] act_base_r;
  logic [ADDR_W-1:0] b_base_r;
  logic [ADDR_W-1:0] r_base_r;

  // Read sequencing. cnt is the index of the read issued this cycle
  // (0..2N) in STREAM, and the cycle index in DRAIN.
  logic [15:0]       neuron;
  logic [32:0]       cnt;
  logic [32:0]       last_idx;
  logic [ADDR_W-1:0] act_ptr;
  logic [ADDR_W-1:0] w_ptr;
  logic              rd_valid;

  logic              cmd_bad;
  logic              stream_last;
  logic              drain_last;
  logic              neuron_last;

  assign last_idx    = {acc_length, 1'b0};
  assign cmd_bad     = (length == 32'd0) || (num_out == 16'd0);
  assign stream_last = (cnt == last_idx);
  assign drain_last  = cnt[0];
  assign neuron_last = (neuron == (num_r - 16'd1));

  // Next-state decode for the per-neuron sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = cmd_bad ? FIN : CLR;
        end
      end
      CLR:    next_state = STREAM;
      STREAM: begin
        if (stream_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          next_state = WRITE;
        end
      end
      WRITE:  next_state = neuron_last ? FIN : CLR;
      FIN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus control outputs, loaded from the next state.
  // Loading them this way keeps the outputs registered and aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc_reset_n <= 1'b0;
      mem_read    <= 1'b0;
      res_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      acc_reset_n <= (next_state != CLR);
      mem_read    <= (next_state == STREAM);
      res_write   <= (next_state == WRITE);
      busy        <= (next_state == CLR) || (next_state == STREAM) ||
                     (next_state == DRAIN) || (next_state == WRITE);
      done        <= (next_state == FIN);
    end
  end

  // Error flag: the verdict on a start command, held until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= cmd_bad;
    end
  end

  // Capture the command. Then step the neuron index after each WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_r      <= '0;
      act_base_r <= '0;
      b_base_r   <= '0;
      r_base_r   <= '0;
      acc_length <= '0;
      neuron     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        num_r      <= num_out;
        act_base_r <= act_base;
        b_base_r   <= b_base;
        r_base_r   <= r_base;
        acc_length <= length;
        neuron     <= '0;
      end
    end else if (state == WRITE && !neuron_last) begin
      neuron <= neuron + 16'd1;
    end
  end

  // Read address generator. Each stream read alternates between an
  // activation and a weight, and the last read is the bias.
  // w_ptr is never rewound between neurons. After a neuron's N weight
  // reads, it already points at the next row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      act_ptr  <= '0;
      w_ptr    <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_ptr <= w_base;
          end
        end
        CLR: begin
          cnt      <= '0;
          mem_addr <= act_base_r;
          act_ptr  <= act_base_r + ADDR_W'(1);
        end
        STREAM: begin
          if (stream_last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 33'd1;
            if ((cnt + 33'd1) == last_idx) begin
              mem_addr <= b_base_r + ADDR_W'(neuron);
            end else if (!cnt[0]) begin
              mem_addr <= w_ptr;
              w_ptr    <= w_ptr + ADDR_W'(1);
            end else begin
              mem_addr <= act_ptr;
              act_ptr  <= act_ptr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          cnt <= cnt + 33'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Stream stage. The header word goes out on the cycle after the first
  // read issues. Read data is re-registered, so the stream has no gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else begin
      rd_valid  <= mem_read;
      acc_valid <= rd_valid || (state == STREAM && cnt == 33'd0);
      acc_data  <= rd_valid ? mem_rdata : 32'd0;
    end
  end

  // Result write. Capture the accelerator result at the end of the drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_addr  <= '0;
      res_wdata <= '0;
    end else if (state == DRAIN && drain_last) begin
      res_addr  <= r_base_r + ADDR_W'(neuron);
      res_wdata <= acc_result;
    end
  end

endmodule

// File: tb/tb_dense_streamer.sv
// Directed testbench for dense_streamer. The bench provides a 1-cycle word
// memory, a result memory and a small Q8.24 accelerator model. It checks
// the stream, the read order, the results and the layer timing.
module tb_dense_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] length = '0;
  logic [15:0] num_out = '0;
  logic [15:0] act_base = '0, w_base = '0, b_base = '0, r_base = '0;
  logic [15:0] mem_addr, res_addr;
  logic        mem_read, res_write, acc_reset_n, acc_valid, busy, done, err;
  logic [31:0] mem_rdata, res_wdata, acc_data, acc_length, acc_result;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_writes = 0;
  int n_clr = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] res_mem [0:65535];
  logic [31:0] sq[$];
  int          cq[$];
  logic [15:0] aq[$];

  dense_streamer #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length), .num_out(num_out),
    .act_base(act_base), .w_base(w_base), .b_base(b_base), .r_base(r_base),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .res_addr(res_addr), .res_wdata(res_wdata), .res_write(res_write),
    .acc_reset_n(acc_reset_n), .acc_data(acc_data), .acc_valid(acc_valid),
    .acc_length(acc_length), .acc_result(acc_result),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle counter: index of the cycle that follows each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with one cycle of read latency.
  always @(posedge clk) mem_rdata <= mem_read ? mem[mem_addr] : 32'd0;

  // Accelerator model: skips the header, multiplies each pair in Q8.24,
  // then adds the bias. The result includes the word on the bus.
  logic [2:0]  ast;
  logic [31:0] a_lat, acc_m, pairs;

  function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[55:24];
  endfunction

  always @(posedge clk or negedge acc_reset_n) begin
    if (!acc_reset_n) begin
      ast <= 3'd0; acc_m <= '0; pairs <= '0; a_lat <= '0;
    end else if (acc_valid) begin
      case (ast)
        3'd0: ast <= 3'd1;
        3'd1: begin a_lat <= acc_data; ast <= 3'd2; end
        3'd2: begin
          acc_m <= acc_m + mulq(a_lat, acc_data);
          pairs <= pairs + 1;
          ast   <= (pairs + 1 == acc_length) ? 3'd3 : 3'd1;
        end
        3'd3: begin acc_m <= acc_m + acc_data; ast <= 3'd4; end
        default: ast <= 3'd4;
      endcase
    end
  end

  assign acc_result = acc_m + ((acc_valid && ast == 3'd3) ? acc_data : 32'd0);

  // Monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (acc_valid) begin sq.push_back(acc_data); cq.push_back(cyc); end
    if (mem_read) aq.push_back(mem_addr);
    if (res_write) begin res_mem[res_addr] = res_wdata; n_writes++; end
    if (!acc_reset_n && !reset) n_clr++;
  end

  task automatic run_layer(input logic [31:0] n, input logic [15:0] m,
                           input logic [15:0] ab, input logic [15:0] wb,
                           input logic [15:0] bb, input logic [15:0] rb,
                           input bit repulse, output int t0, output int done_at,
                           output bit err_at, output bit timed_out);
    @(negedge clk);
    sq.delete(); cq.delete(); aq.delete(); n_writes = 0; n_clr = 0;
    length = n; num_out = m; act_base = ab; w_base = wb; b_base = bb; r_base = rb;
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1; done_at = -1; err_at = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin timed_out = 1'b0; done_at = cyc; err_at = err; break; end
      start = (repulse && (cyc == t0 + 3 || cyc == t0 + 6)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if (acc_reset_n !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_acc_reset_n got %b want 0", acc_reset_n); end
    vectors++;
    if ({busy, done, err, mem_read, acc_valid, res_write} !== 6'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags got %b want 000000", {busy, done, err, mem_read, acc_valid, res_write});
    end
    vectors++;
    if ({mem_addr, res_addr, acc_data, res_wdata, acc_length} !== 128'd0) begin
      miscompares++; $display("[TB] FAIL reset_data got %h want 0", {mem_addr, res_addr, acc_data, res_wdata, acc_length});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (acc_reset_n !== 1'b1) begin miscompares++; $display("[TB] FAIL release_acc_reset_n got %b want 1", acc_reset_n); end
  endtask

  task automatic test_zero;
    int t0, d; bit e, to;
    run_layer(32'd0, 16'd3, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, t0, d, e, to);
    vectors++;
    if (to || d != t0 + 1 || e !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_len_done got t+%0d err=%b want t+1 err=1", d - t0, e); end
    vectors++;
    if (aq.size() != 0 || sq.size() != 0 || n_writes != 0) begin
      miscompares++; $display("[TB] FAIL zero_len_activity got reads=%0d valids=%0d writes=%0d want 0", aq.size(), sq.size(), n_writes);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL err_hold got err=%b done=%b want 1 0", err, done); end
    run_layer(32'd2, 16'd0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, t0, d, e, to);
    vectors++;
    if (to || d != t0 + 1 || e !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_num_done got t+%0d err=%b want t+1 err=1", d - t0, e); end
    vectors++;
    if (aq.size() != 0 || sq.size() != 0 || n_writes != 0) begin
      miscompares++; $display("[TB] FAIL zero_num_activity got reads=%0d valids=%0d writes=%0d want 0", aq.size(), sq.size(), n_writes);
    end
  endtask

  task automatic test_basic(input bit repulse);
    int t0, d; bit e, to;
    logic [31:0] exp_s [6];
    logic [15:0] exp_a [5];
    exp_s = '{32'h0, 32'h01000000, 32'h00800000, 32'h02000000, 32'h00400000, 32'h00200000};
    exp_a = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0300};
    res_mem[16'h0400] = 32'h0;
    run_layer(32'd2, 16'd1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, repulse, t0, d, e, to);
    vectors++;
    if (to || d != t0 + 10 || e !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done got t+%0d err=%b want t+10 err=0", d - t0, e); end
    vectors++;
    if (sq.size() != 6) begin
      miscompares++; $display("[TB] FAIL basic_stream_len got %0d want 6", sq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (sq[i] !== exp_s[i]) begin miscompares++; $display("[TB] FAIL basic_word%0d got %h want %h", i, sq[i], exp_s[i]); end
      end
      vectors++;
      if (cq[0] != t0 + 3 || cq[5] != t0 + 8) begin
        miscompares++; $display("[TB] FAIL basic_valid_window got t+%0d..t+%0d want t+3..t+8", cq[0] - t0, cq[5] - t0);
      end
    end
    vectors++;
    if (aq.size() != 5) begin
      miscompares++; $display("[TB] FAIL basic_read_count got %0d want 5", aq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (aq[i] !== exp_a[i]) begin miscompares++; $display("[TB] FAIL basic_addr%0d got %h want %h", i, aq[i], exp_a[i]); end
      end
    end
    vectors++;
    if (res_mem[16'h0400] !== 32'h01200000 || n_writes != 1) begin
      miscompares++; $display("[TB] FAIL basic_result got %h writes=%0d want 01200000 writes=1", res_mem[16'h0400], n_writes);
    end
    vectors++;
    if (n_clr != 1 || acc_length !== 32'd2) begin
      miscompares++; $display("[TB] FAIL basic_clr_len got clr=%0d len=%0d want 1 2", n_clr, acc_length);
    end
  endtask

  task automatic test_multi;
    int t0, d; bit e, to;
    for (int i = 0; i < 3; i++) res_mem[16'h0800 + i] = 32'h0;
    run_layer(32'd1, 16'd3, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0, t0, d, e, to);
    vectors++;
    if (to || d != t0 + 22) begin miscompares++; $display("[TB] FAIL multi_done got t+%0d want t+22", d - t0); end
    vectors++;
    if (res_mem[16'h0800] !== 32'h01000000 || res_mem[16'h0801] !== 32'h02000000 || res_mem[16'h0802] !== 32'h03000000) begin
      miscompares++; $display("[TB] FAIL multi_results got %h %h %h want 01000000 02000000 03000000",
                              res_mem[16'h0800], res_mem[16'h0801], res_mem[16'h0802]);
    end
    vectors++;
    if (n_clr != 3 || n_writes != 3 || sq.size() != 12) begin
      miscompares++; $display("[TB] FAIL multi_counts got clr=%0d writes=%0d valids=%0d want 3 3 12", n_clr, n_writes, sq.size());
    end
    vectors++;
    if (aq.size() != 9) begin
      miscompares++; $display("[TB] FAIL multi_reads got %0d want 9", aq.size());
    end else if (aq[4] !== 16'h0601 || aq[8] !== 16'h0702) begin
      miscompares++; $display("[TB] FAIL multi_addrs got %h %h want 0601 0702", aq[4], aq[8]);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    for (int i = 0; i < 3; i++) res_mem[16'h0800 + i] = 32'h0;
    @(negedge clk);
    n_writes = 0;
    length = 32'd1; num_out = 16'd3; act_base = 16'h0500; w_base = 16'h0600; b_base = 16'h0700; r_base = 16'h0800;
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_stream got read=%b busy=%b want 1 1", mem_read, busy); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, mem_read, acc_valid, res_write, acc_reset_n} !== 6'b0 || {mem_addr, acc_data} !== 48'd0) begin
      miscompares++; $display("[TB] FAIL abort_values got flags=%b addr=%h data=%h want 0", {busy, done, mem_read, acc_valid, res_write, acc_reset_n}, mem_addr, acc_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (n_writes != 1 || res_mem[16'h0801] !== 32'h0) begin
      miscompares++; $display("[TB] FAIL abort_writes got writes=%0d r1=%h want 1 0", n_writes, res_mem[16'h0801]);
    end
  endtask

  task automatic test_wrap;
    int t0, d; bit e, to;
    res_mem[16'h0030] = 32'h0;
    run_layer(32'd2, 16'd1, 16'h0010, 16'hFFFF, 16'h0020, 16'h0030, 1'b0, t0, d, e, to);
    vectors++;
    if (to || aq.size() != 5) begin
      miscompares++; $display("[TB] FAIL wrap_reads got %0d want 5", aq.size());
    end else if (aq[1] !== 16'hFFFF || aq[3] !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL wrap_addrs got %h %h want ffff 0000", aq[1], aq[3]);
    end
    vectors++;
    if (res_mem[16'h0030] !== 32'h01200000) begin
      miscompares++; $display("[TB] FAIL wrap_result got %h want 01200000", res_mem[16'h0030]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 32'h0; res_mem[i] = 32'h0; end
    mem[16'h0100] = 32'h01000000; mem[16'h0101] = 32'h02000000;
    mem[16'h0200] = 32'h00800000; mem[16'h0201] = 32'h00400000;
    mem[16'h0300] = 32'h00200000;
    mem[16'h0500] = 32'h01000000;
    mem[16'h0600] = 32'h01000000; mem[16'h0601] = 32'h02000000; mem[16'h0602] = 32'h03000000;
    mem[16'h0010] = 32'h01000000; mem[16'h0011] = 32'h02000000;
    mem[16'hFFFF] = 32'h00800000; mem[16'h0000] = 32'h00400000;
    mem[16'h0020] = 32'h00200000;

    test_reset;
    test_zero;
    test_basic(1'b0);
    test_multi;
    test_reset_mid;
    test_multi;
    test_basic(1'b1);
    test_wrap;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dense_streamer.md
# dense_streamer

Sequencer on the transmit side of the dense-layer accelerator's word-stream interface. Fetches activations, weights and biases from a 1-cycle-latency word memory and emits them as a contiguous valid stream: header, then (activation, weight) pairs, then bias. Pulses the accelerator's active-low reset before each output neuron and writes each captured Q8.24 result to a result memory. One start command computes a full layer of `num_out` neurons.

## Interface
- `ADDR_W`, 16, width of all memory addresses
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: 1-cycle command pulse; sampled only in IDLE
- `length` in 32: inputs per neuron (N)
- `num_out` in 16: neurons in the layer (M)
- `act_base`, `w_base`, `b_base`, `r_base` in ADDR_W each: activation vector, weight matrix (row-major, N words per neuron), bias vector, result vector
- `mem_addr` out ADDR_W: read address
- `mem_read` out 1: read strobe; data on `mem_rdata` the following cycle
- `mem_rdata` in 32: read data
- `res_addr` out ADDR_W, `res_wdata` out 32, `res_write` out 1: result write port, single-cycle writes
- `acc_reset_n` out 1: accelerator reset, active-low
- `acc_data` out 32, `acc_valid` out 1: stream to accelerator
- `acc_length` out 32: N, latched at start
- `acc_result` in 32: accelerator accumulator output
- `busy` out 1, `done` out 1, `err` out 1

## Operation
- States: IDLE, CLR, STREAM, DRAIN, WRITE, FIN.
- IDLE: when `start` is seen, latch all command inputs.
  - `length`==0 or `num_out`==0: go to FIN with `err`=1; nothing is streamed.
  - Otherwise go to CLR with neuron index j=0 and `busy`=1.
- CLR (1 cycle): `acc_reset_n`=0. This is required because the accelerator's pair counter and accumulator clear only on its reset.
- STREAM (2N+1 cycles): one read per cycle, in this order:
  - for i=0..N-1: `act_base`+i, then `wptr`+i
  - then `b_base`+j
  - `wptr` starts at `w_base` and advances by N after each neuron.
- Stream word 0 is the header: constant 0, not read from memory.
- Words 1..2N+1 are the read data, registered once, in issue order.
- DRAIN (2 cycles): no reads; the last words flush out of the stream.
- WRITE (1 cycle): `res_write`=1, `res_addr`=`r_base`+j, `res_wdata`=`acc_result`.
  - If j<M-1: j++, go to CLR.
  - Otherwise go to FIN.
- FIN (1 cycle): `done`=1, `busy`=0. Then go to IDLE.
- All address arithmetic is modulo 2^ADDR_W; pointers wrap silently.
- `start` while not in IDLE is ignored.
- `err` holds until the next accepted start.

## Timing
- Reset values while `reset`=1: state IDLE; `acc_reset_n`=0; `acc_valid`, `mem_read`, `res_write`, `busy`, `done`, `err`=0; all data and address outputs 0.
- `acc_reset_n` rises at the first clock edge after `reset` falls. It is 0 only in CLR thereafter.
- All outputs are registered. Nothing combinational runs from an input to an output.
- Per-neuron timing, with CLR at cycle C:
  - reads issued in cycles C+1..C+2N+1
  - `acc_valid`=1 in exactly cycles C+2..C+2N+3, with no gaps, and 0 at all other times
  - header in C+2, activation i in C+3+2i, weight i in C+4+2i, bias in C+2N+3
  - WRITE at C+2N+4
  - next CLR at C+2N+5
- The no-gap rule on `acc_valid` is mandatory: the accelerator accumulates on every cycle it sits in its weight and bias states.
- Layer latency: `start` at cycle T → first CLR at T+1 → `done` at T+1+M(2N+5).
- Reset mid-operation aborts immediately to the reset values. `acc_reset_n`=0 also clears the accelerator. No partial result is written.

## Test plan
- N=2, M=1, act=[0x01000000, 0x02000000], w=[0x00800000, 0x00400000], bias=0x00200000 → stream is 0, 0x01000000, 0x00800000, 0x02000000, 0x00400000, 0x00200000 on 6 consecutive cycles; `res_wdata`=0x01200000 at `r_base`; `done` at T+10.
- N=1, M=3, act=[0x01000000], weights=[1,2,3]×0x01000000, biases 0 → results 0x01000000, 0x02000000, 0x03000000 at `r_base`..+2; one CLR pulse per neuron; `done` at T+22.
- `length`=0 (and separately `num_out`=0) → no `mem_read`, no `acc_valid`; `done`=`err`=1 at T+1.
- `reset` asserted during the STREAM of neuron 1 of M=3 → outputs take reset values within the same cycle; no further `res_write`; after release, a fresh start gives correct results.
- `start` re-pulsed while `busy` → ignored; results and timing match the single-start run.
- ADDR_W=16, `w_base`=0xFFFF, N=2 → weight reads at 0xFFFF then 0x0000; result correct.
